// File: rtl/srt_div10_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : srt_pkg                                                       |
// | Purpose    : Shared widths, FSM state encoding, mux select codes and the   |
// |              quotient-digit encoding for the radix-2 SRT divider stage.    |
// | Contents   : W, IT, WW (remainder width), CW (counter width),              |
// |              state_t, qdig_t, SEL_* select codes.                          |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package srt_pkg;

  // Operand width is tied to the downstream 10-bit 3:1 mux.
  localparam int W  = 10;
  // One quotient digit per iteration, one iteration per operand bit.
  localparam int IT = W;
  // Partial remainder: two extra integer/sign bits so 2*w never overflows.
  localparam int WW = W + 2;
  // Iteration counter width.
  localparam int CW = $clog2(IT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Quotient digit in {+1, 0, -1}.
  typedef enum logic [1:0] {
    QD_ZERO = 2'b00,
    QD_POS  = 2'b01,
    QD_NEG  = 2'b11
  } qdig_t;

  // Mux leg select codes. Leg a carries ~d and is used to subtract d
  // (digit +1, carry-in supplied by this stage); leg c carries d (digit -1).
  localparam logic [1:0] SEL_NEG_D = 2'b00;
  localparam logic [1:0] SEL_ZERO  = 2'b01;
  localparam logic [1:0] SEL_POS_D = 2'b10;

endpackage
`default_nettype wire

// File: rtl/srt_div10_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : srt_div10_iter_if                                             |
// | Purpose    : Bundles the divider request/response handshake and the        |
// |              operand/select bus to the external 3:1 multiple-select mux.   |
// | Signals    : start, x, d            request side (master drives)           |
// |              busy, done, err,       response side (divider drives)         |
// |              quotient, rem                                                 |
// |              mux_a, mux_b, mux_c,   mux operands + select (divider drives) |
// |              mux_s                                                         |
// |              mux_y                  mux result (mux side drives)           |
// | Modports   : master = requester + mux; slave = divider stage              |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface srt_div10_iter_if;
  import srt_pkg::*;

  logic          start;
  logic [W-1:0]  x;
  logic [W-1:0]  d;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  quotient;
  logic [WW-1:0] rem;
  logic [W-1:0]  mux_a;
  logic [W-1:0]  mux_b;
  logic [W-1:0]  mux_c;
  logic [1:0]    mux_s;
  logic [W-1:0]  mux_y;

  modport master (
    output start, x, d, mux_y,
    input  busy, done, err, quotient, rem, mux_a, mux_b, mux_c, mux_s
  );

  modport slave (
    input  start, x, d, mux_y,
    output busy, done, err, quotient, rem, mux_a, mux_b, mux_c, mux_s
  );

endinterface
`default_nettype wire

// File: rtl/srt_div10_iter_qsel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : srt_qsel                                                      |
// | Purpose    : Radix-2 SRT quotient-digit selection from the top four bits   |
// |              of the shifted partial remainder.                             |
// | Ports      : t_hi  in  4   t[11:8] of t = 2w, read as signed quarters      |
// |              digit out 2   selected digit (+1 / 0 / -1)                    |
// |              sel   out 2   matching mux select code                        |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module srt_qsel
  import srt_pkg::*;
(
  input  logic [3:0] t_hi,
  output qdig_t      digit,
  output logic [1:0] sel
);

  // t_hi is floor(4*t): the estimate truncates toward -inf, so the
  // thresholds below give +1 for t >= 0.5 and -1 for t < -0.5.
  logic signed [3:0] y4;
  assign y4 = $signed(t_hi);

  always_comb begin
    digit = QD_ZERO;
    sel   = SEL_ZERO;
    if (y4 >= 4'sd2) begin
      digit = QD_POS;
      sel   = SEL_NEG_D;
    end else if (y4 < -4'sd2) begin
      digit = QD_NEG;
      sel   = SEL_POS_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/srt_div10_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : srt_div10_iter                                                |
// | Purpose    : Radix-2 SRT fractional divider control/datapath stage, 10 bit.|
// |              Picks one quotient digit per cycle, drives the external 3:1   |
// |              mux (~d, 0, d) and folds its output into the partial          |
// |              remainder. On-the-fly quotient conversion (Q / QM).           |
// | Ports      : clk    in  1   rising-edge clock                              |
// |              rst_n  in  1   asynchronous active-low reset                  |
// |              bus    slave   start/x/d in; busy/done/err/quotient/rem out;  |
// |                             mux_a/b/c/s out; mux_y in (same-cycle)         |
// | Latency    : load edge 0 -> done high in the cycle after edge 12           |
// |              (operand error: cycle after edge 1).                          |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module srt_div10_iter
  import srt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  srt_div10_iter_if.slave       bus
);

  state_t         state;
  state_t         state_nxt;

  logic [WW-1:0]  w;          // partial remainder, two's complement
  logic [W-1:0]   q_acc;      // on-the-fly Q
  logic [W-1:0]   qm_acc;     // on-the-fly Q - 1ulp
  logic [CW-1:0]  cnt;
  logic [W-1:0]   d_reg;
  logic           err_pend;   // operand error seen at the accepted start

  logic           busy_reg;
  logic           done_reg;
  logic           err_reg;
  logic [W-1:0]   quot_reg;
  logic [WW-1:0]  rem_reg;

  logic           bad_ops;
  logic           accept;
  logic [1:0]     sel;
  qdig_t          digit;
  logic [1:0]     qsel_sel;
  logic [WW-1:0]  t;
  logic [WW-1:0]  ext;
  logic [WW-1:0]  w_iter;
  logic [WW-1:0]  w_fix;

  // --------------------------------------------------------------------------
  // Request qualification. busy is still high during the done cycle, so a
  // start there is treated as arriving while busy and dropped.
  // --------------------------------------------------------------------------
  assign bad_ops = ~bus.d[W-1] | (bus.x >= bus.d);
  assign accept  = (state == IDLE) & bus.start & ~busy_reg;

  // --------------------------------------------------------------------------
  // Digit selection and remainder update
  // --------------------------------------------------------------------------
  assign t = {w[WW-2:0], 1'b0};

  srt_qsel u_qsel (
    .t_hi  (t[WW-1:WW-4]),
    .digit (digit),
    .sel   (qsel_sel)
  );

  // For digit +1 the mux returns ~d; sign-extend it as negative and add the
  // carry-in so the sum is t - d.
  assign ext    = (digit == QD_POS) ? {2'b11, bus.mux_y} : {2'b00, bus.mux_y};
  assign w_iter = t + ext + {{(WW-1){1'b0}}, (digit == QD_POS)};
  assign w_fix  = w + {2'b00, bus.mux_y};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and mux select
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    sel       = SEL_ZERO;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = bad_ops ? DONE : ITER;
        end
      end
      ITER: begin
        sel = qsel_sel;
        if (cnt == CW'(IT - 1)) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        // A negative final remainder is corrected by adding d once.
        sel       = w[WW-1] ? SEL_POS_D : SEL_ZERO;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and handshake registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w        <= '0;
      q_acc    <= '0;
      qm_acc   <= '0;
      cnt      <= '0;
      d_reg    <= '0;
      err_pend <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      quot_reg <= '0;
      rem_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (done_reg) begin
        busy_reg <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            busy_reg <= 1'b1;
            err_pend <= bad_ops;
            if (!bad_ops) begin
              d_reg  <= bus.d;
              w      <= {2'b00, bus.x};
              q_acc  <= '0;
              qm_acc <= '0;
              cnt    <= '0;
            end
          end
        end
        ITER: begin
          w   <= w_iter;
          cnt <= cnt + 1'b1;
          case (digit)
            QD_POS: begin
              q_acc  <= {q_acc[W-2:0], 1'b1};
              qm_acc <= {q_acc[W-2:0], 1'b0};
            end
            QD_NEG: begin
              q_acc  <= {qm_acc[W-2:0], 1'b1};
              qm_acc <= {qm_acc[W-2:0], 1'b0};
            end
            default: begin
              q_acc  <= {q_acc[W-2:0], 1'b0};
              qm_acc <= {qm_acc[W-2:0], 1'b1};
            end
          endcase
        end
        FIX: begin
          if (w[WW-1]) begin
            w     <= w_fix;
            q_acc <= qm_acc;
          end
        end
        DONE: begin
          done_reg <= 1'b1;
          err_reg  <= err_pend;
          quot_reg <= err_pend ? {W{1'b1}} : q_acc;
          rem_reg  <= err_pend ? {WW{1'b0}} : w;
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.mux_a    = ~d_reg;
  assign bus.mux_b    = '0;
  assign bus.mux_c    = d_reg;
  assign bus.mux_s    = sel;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.err      = err_reg;
  assign bus.quotient = quot_reg;
  assign bus.rem      = rem_reg;

`ifndef SYNTHESIS
  // Convergence invariant: |w| < d throughout the digit iterations.
  logic [WW-1:0] w_mag;
  assign w_mag = w[WW-1] ? (~w + {{(WW-1){1'b0}}, 1'b1}) : w;

  always_ff @(posedge clk) begin
    if (rst_n && (state == ITER)) begin
      assert (w_mag < {2'b00, d_reg})
        else $error("srt_div10_iter: |w| >= d during iteration");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_srt_div10_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_srt_div10_iter                                             |
// | Purpose    : Self-checking bench for srt_div10_iter with a behavioural     |
// |              3:1 mux and a scoreboard of expected quotient/remainder.      |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_srt_div10_iter;
  import srt_pkg::*;

  logic clk;
  logic rst_n;

  srt_div10_iter_if bus ();

  srt_div10_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural stand-in for the downstream mux31x10.
  assign bus.mux_y = (bus.mux_s == SEL_NEG_D) ? bus.mux_a :
                     (bus.mux_s == SEL_ZERO)  ? bus.mux_b : bus.mux_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  q;
    logic [WW-1:0] r;
    logic          e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   sel11    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.mux_s == 2'b11) sel11++;
    if (rst_n && bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", 32'(bus.quotient), 32'(mon_e.q));
        chk("rem", 32'(bus.rem), 32'(mon_e.r));
        chk("err", 32'(bus.err), 32'(mon_e.e));
        chk("busy_at_done", 32'(bus.busy), 32'd1);
      end
    end
  end

  // Reference: X*1024 = Q*D + R with 0 <= R < D.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] d);
    exp_t        e;
    int unsigned num;
    if (!d[W-1] || (x >= d)) begin
      e.q = '1;
      e.r = '0;
      e.e = 1'b1;
    end else begin
      num = 32'(x) << W;
      e.q = W'(num / 32'(d));
      e.r = WW'(num % 32'(d));
      e.e = 1'b0;
    end
    return e;
  endfunction

  // Drive one request through its load edge; returns at #1 after that edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] d, input bit push);
    int k = 0;
    @(negedge clk);
    while (bus.busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk("idle_timeout", 32'd1, 32'd0);
    bus.start = 1'b1;
    bus.x     = x;
    bus.d     = d;
    if (push) sb.push_back(model(x, d));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges after the load edge until done is seen.
  task automatic wait_done(input int already, input int lat);
    int n = already;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] d);
    int lat;
    lat = (!d[W-1] || (x >= d)) ? 1 : 12;
    launch(x, d, 1'b1);
    wait_done(0, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    logic [W-1:0] rx;
    logic [W-1:0] rd;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.d     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_quot", 32'(bus.quotient), 32'd0);
    chk("rst_rem", 32'(bus.rem), 32'd0);
    chk("rst_mux_s", 32'(bus.mux_s), 32'(SEL_ZERO));
    chk("rst_mux_a", 32'(bus.mux_a), 32'h3FF);
    chk("rst_mux_b", 32'(bus.mux_b), 32'd0);
    chk("rst_mux_c", 32'(bus.mux_c), 32'd0);

    // Directed vectors
    run_op(10'h100, 10'h200);
    run_op(10'h155, 10'h300);
    run_op(10'h3FE, 10'h3FF);
    run_op(10'h000, 10'h3FF);
    run_op(10'h000, 10'h0FF);
    run_op(10'h200, 10'h200);
    run_op(10'h1FF, 10'h200);

    // Start re-pulsed mid-operation must be ignored.
    launch(10'h155, 10'h300, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 10'h001;
    bus.d     = 10'h3FF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_mid_op", 32'(bus.busy), 32'd1);
    wait_done(5, 12);
    repeat (20) @(posedge clk);
    chk("sb_after_repulse", 32'(sb.size()), 32'd0);

    // Reset mid-operation: immediate clear, no done.
    launch(10'h3FE, 10'h3FF, 1'b0);
    done_before = n_done;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_quot", 32'(bus.quotient), 32'd0);
    chk("midrst_rem", 32'(bus.rem), 32'd0);
    chk("midrst_mux_s", 32'(bus.mux_s), 32'(SEL_ZERO));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("no_done_after_rst", 32'(n_done), 32'(done_before));

    // Random vectors, mostly legal, with an occasional x == d error case.
    for (int i = 0; i < 2500; i++) begin
      rd = 10'h200 | 10'($urandom_range(0, 511));
      if (i % 97 == 0) rx = rd;
      else             rx = 10'($urandom_range(0, int'(rd) - 1));
      run_op(rx, rd);
    end

    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("mux_s_never_11", 32'(sel11), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
